// File: rtl/sargantana_icache_valid_arb_if.sv
// Valid-RAM arbiter bus bundle.
// Carries the flush, invalidate, refill and lookup request/grant handshakes
// plus the valid-RAM access bus. The signal suffixes are from the arbiter's
// point of view:
//   slave  - the arbiter: takes *_i, drives *_o
//   master - the requesters and valid RAM: drive *_i, observe *_o
interface sargantana_icache_valid_arb_if #(
  parameter int IDX_WIDTH = 6,
  parameter int N_WAY     = 4
);
  localparam int WAY_W = $clog2(N_WAY);

  logic                 flush_req_i;
  logic                 flush_busy_o;
  logic                 flush_done_o;
  logic                 inval_req_i;
  logic [IDX_WIDTH-1:0] inval_idx_i;
  logic                 wr_req_i;
  logic [IDX_WIDTH-1:0] wr_idx_i;
  logic [WAY_W-1:0]     wr_way_i;
  logic                 rd_req_i;
  logic [IDX_WIDTH-1:0] rd_idx_i;
  logic                 inval_gnt_o;
  logic                 wr_gnt_o;
  logic                 rd_gnt_o;
  logic [N_WAY-1:0]     vram_en_o;
  logic                 vram_we_o;
  logic [IDX_WIDTH-1:0] vram_idx_o;
  logic [N_WAY-1:0]     vram_wdata_o;

  modport slave (
    input  flush_req_i, inval_req_i, inval_idx_i, wr_req_i, wr_idx_i,
           wr_way_i, rd_req_i, rd_idx_i,
    output flush_busy_o, flush_done_o, inval_gnt_o, wr_gnt_o, rd_gnt_o,
           vram_en_o, vram_we_o, vram_idx_o, vram_wdata_o
  );

  modport master (
    output flush_req_i, inval_req_i, inval_idx_i, wr_req_i, wr_idx_i,
           wr_way_i, rd_req_i, rd_idx_i,
    input  flush_busy_o, flush_done_o, inval_gnt_o, wr_gnt_o, rd_gnt_o,
           vram_en_o, vram_we_o, vram_idx_o, vram_wdata_o
  );
endinterface

// File: rtl/sargantana_icache_valid_arb.sv
// Instruction-cache valid-bit RAM arbiter.
// Arbitrates single-cycle access to the valid-bit RAM between a full-cache
// flush walk, single-set invalidation, refill valid-set and core lookup.
// Ports:
//   clk_i  - clock, all state on rising edge
//   rst_i  - synchronous active-high reset
//   bus_if - request/grant handshakes and valid-RAM bus (slave modport)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | fixed-priority grant inval > wr > rd; flush_req starts a walk
// FLUSH | one set cleared per cycle, counter 0..S-1, no grants
module sargantana_icache_valid_arb #(
  parameter int IDX_WIDTH = 6,
  parameter int N_WAY     = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  sargantana_icache_valid_arb_if.slave  bus_if
);

  typedef enum logic {ST_IDLE, ST_FLUSH} state_e;

  localparam logic [IDX_WIDTH-1:0] IDX_LAST = {IDX_WIDTH{1'b1}};

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    pend_d              = pend_q;
    done_d              = 1'b0;
    bus_if.inval_gnt_o  = 1'b0;
    bus_if.wr_gnt_o     = 1'b0;
    bus_if.rd_gnt_o     = 1'b0;
    bus_if.flush_busy_o = 1'b0;
    bus_if.vram_en_o    = '0;
    bus_if.vram_we_o    = 1'b0;
    bus_if.vram_idx_o   = '0;
    bus_if.vram_wdata_o = '0;

    // Outputs are held quiet while reset is asserted; the register
    // reset itself is handled in the always_ff.
    if (!rst_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus_if.flush_req_i) begin
            state_d = ST_FLUSH;
            cnt_d   = '0;
          end else if (bus_if.inval_req_i) begin
            bus_if.inval_gnt_o = 1'b1;
            bus_if.vram_en_o   = '1;
            bus_if.vram_we_o   = 1'b1;
            bus_if.vram_idx_o  = bus_if.inval_idx_i;
          end else if (bus_if.wr_req_i) begin
            bus_if.wr_gnt_o     = 1'b1;
            bus_if.vram_en_o    = N_WAY'(1) << bus_if.wr_way_i;
            bus_if.vram_we_o    = 1'b1;
            bus_if.vram_idx_o   = bus_if.wr_idx_i;
            bus_if.vram_wdata_o = N_WAY'(1) << bus_if.wr_way_i;
          end else if (bus_if.rd_req_i) begin
            bus_if.rd_gnt_o   = 1'b1;
            bus_if.vram_en_o  = '1;
            bus_if.vram_idx_o = bus_if.rd_idx_i;
          end
        end
        ST_FLUSH: begin
          bus_if.flush_busy_o = 1'b1;
          bus_if.vram_en_o    = '1;
          bus_if.vram_we_o    = 1'b1;
          bus_if.vram_idx_o   = cnt_q;
          cnt_d               = cnt_q + IDX_WIDTH'(1);
          if (bus_if.flush_req_i) pend_d = 1'b1;
          if (cnt_q == IDX_LAST) begin
            done_d = 1'b1;
            // A request arriving on the final write counts as pending too,
            // so it chains straight into the next walk.
            if (pend_q || bus_if.flush_req_i) begin
              state_d = ST_FLUSH;
              pend_d  = 1'b0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus_if.flush_done_o = done_q;

endmodule

// File: tb/tb_sargantana_icache_valid_arb.sv
module tb_sargantana_icache_valid_arb;
  localparam int IW = 2;
  localparam int NW = 4;
  localparam int S  = 1 << IW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sargantana_icache_valid_arb_if #(.IDX_WIDTH(IW), .N_WAY(NW)) vif ();

  sargantana_icache_valid_arb #(.IDX_WIDTH(IW), .N_WAY(NW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_if(vif.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: the flush engine is a queue of set indices still to be
  // cleared; a queued second walk stands in for the pending request.
  int   walk_q[$];
  logic exp_done = 1'b0;

  logic          e_ig, e_wg, e_rg, e_busy, e_we;
  logic [NW-1:0] e_en, e_wd;
  logic [IW-1:0] e_idx;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Inputs are already driven (at the falling edge); settle, compare against
  // the model, advance the model, then move to the next falling edge.
  task automatic step();
    int popped;
    #1;
    e_ig = 0; e_wg = 0; e_rg = 0; e_busy = 0; e_we = 0;
    e_en = '0; e_wd = '0; e_idx = '0;
    if (!rst) begin
      if (walk_q.size() > 0) begin
        e_busy = 1; e_en = '1; e_we = 1; e_idx = IW'(walk_q[0]);
      end else if (vif.flush_req_i) begin
        // flush request takes the cycle, nothing granted
      end else if (vif.inval_req_i) begin
        e_ig = 1; e_en = '1; e_we = 1; e_idx = vif.inval_idx_i;
      end else if (vif.wr_req_i) begin
        e_wg = 1; e_we = 1; e_idx = vif.wr_idx_i;
        e_en = '0; e_en[vif.wr_way_i] = 1'b1; e_wd = e_en;
      end else if (vif.rd_req_i) begin
        e_rg = 1; e_en = '1; e_idx = vif.rd_idx_i;
      end
    end
    check_val("gnt",   {vif.inval_gnt_o, vif.wr_gnt_o, vif.rd_gnt_o}, {e_ig, e_wg, e_rg});
    check_val("en",    vif.vram_en_o, e_en);
    check_val("we",    vif.vram_we_o, e_we);
    check_val("idx",   vif.vram_idx_o, e_idx);
    check_val("wdata", vif.vram_wdata_o, e_wd);
    check_val("busy",  vif.flush_busy_o, e_busy);
    check_val("done",  vif.flush_done_o, exp_done);
    if (rst) begin
      walk_q.delete();
      exp_done = 0;
    end else if (walk_q.size() > 0) begin
      popped = walk_q.pop_front();
      exp_done = (popped == S - 1);
      if (vif.flush_req_i && walk_q.size() < S)
        for (int i = 0; i < S; i++) walk_q.push_back(i);
    end else begin
      exp_done = 0;
      if (vif.flush_req_i)
        for (int i = 0; i < S; i++) walk_q.push_back(i);
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    vif.flush_req_i = 0; vif.inval_req_i = 0; vif.inval_idx_i = '0;
    vif.wr_req_i = 0; vif.wr_idx_i = '0; vif.wr_way_i = '0;
    vif.rd_req_i = 0; vif.rd_idx_i = '0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    @(negedge clk);
    vif.rd_req_i = 1; vif.inval_req_i = 1;
    step(); step();              // outputs must stay quiet under reset
    rst = 0; clear_inputs();
    step();

    // Priority: all three requesters at once
    vif.inval_req_i = 1; vif.inval_idx_i = 2;
    vif.wr_req_i = 1; vif.wr_idx_i = 1; vif.wr_way_i = 3;
    vif.rd_req_i = 1; vif.rd_idx_i = 0;
    #1;
    check_val("prio_gnt", {vif.inval_gnt_o, vif.wr_gnt_o, vif.rd_gnt_o}, 3'b100);
    check_val("prio_en", vif.vram_en_o, 4'b1111);
    step();
    clear_inputs();

    // Refill alone
    vif.wr_req_i = 1; vif.wr_idx_i = 3; vif.wr_way_i = 2;
    #1;
    check_val("refill_en", vif.vram_en_o, 4'b0100);
    check_val("refill_wdata", vif.vram_wdata_o, 4'b0100);
    step();
    clear_inputs();

    // Flush with a lookup held throughout
    vif.flush_req_i = 1; vif.rd_req_i = 1; vif.rd_idx_i = 1;
    step();                      // T
    vif.flush_req_i = 0;
    for (int i = 0; i < S; i++) begin
      #1;
      check_val("flush_walk_idx", vif.vram_idx_o, i);
      check_val("flush_walk_rdgnt", vif.rd_gnt_o, 0);
      step();                    // T+1..T+4
    end
    #1;
    check_val("flush_done_pulse", vif.flush_done_o, 1);
    check_val("flush_rd_after", vif.rd_gnt_o, 1);
    step();                      // T+5
    clear_inputs();
    step();

    // Re-flush: second request at T+2
    vif.flush_req_i = 1; step(); // T
    vif.flush_req_i = 0; step(); // T+1
    vif.flush_req_i = 1; step(); // T+2
    vif.flush_req_i = 0;
    for (int c = 3; c <= 9; c++) begin
      #1;
      check_val("reflush_busy", vif.flush_busy_o, (c <= 8) ? 1 : 0);
      check_val("reflush_done", vif.flush_done_o, (c == 5 || c == 9) ? 1 : 0);
      step();
    end

    // Reset in the middle of a walk
    vif.flush_req_i = 1; step(); // T
    vif.flush_req_i = 0; step(); // T+1
    rst = 1; step();             // T+2
    rst = 0; vif.rd_req_i = 1; vif.rd_idx_i = 3;
    #1;
    check_val("rst_abort_busy", vif.flush_busy_o, 0);
    check_val("rst_abort_rdgnt", vif.rd_gnt_o, 1);
    step();
    clear_inputs();
    for (int i = 0; i < S + 2; i++) step();  // no stray done pulse

    // Randomized traffic; requesters hold until granted
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst = ($urandom_range(0, 79) == 0);
      vif.flush_req_i = ($urandom_range(0, 9) == 0);
      if (!vif.inval_req_i && $urandom_range(0, 3) == 0) begin
        vif.inval_req_i = 1; vif.inval_idx_i = IW'($urandom);
      end
      if (!vif.wr_req_i && $urandom_range(0, 2) == 0) begin
        vif.wr_req_i = 1; vif.wr_idx_i = IW'($urandom); vif.wr_way_i = 2'($urandom);
      end
      if (!vif.rd_req_i && $urandom_range(0, 1) == 0) begin
        vif.rd_req_i = 1; vif.rd_idx_i = IW'($urandom);
      end
      step();
      if (e_ig) vif.inval_req_i = 0;
      if (e_wg) vif.wr_req_i = 0;
      if (e_rg) vif.rd_req_i = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sargantana_icache_valid_arb.md
SARGANTANA_ICACHE_VALID_ARB -- requirements
Module: sargantana_icache_valid_arb

Interface
REQ-001 SHALL have parameter IDX_WIDTH, default 6, set-index width (number of sets S = 2^IDX_WIDTH).
REQ-002 SHALL have parameter N_WAY, default 4, number of ways (power of two, >= 2).
REQ-003 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port flush_req_i  input  1  request to invalidate every set, all ways.
REQ-006 SHALL have port flush_busy_o  output  1  flush walk in progress.
REQ-007 SHALL have port flush_done_o  output  1  one-cycle pulse when the walk completes.
REQ-008 SHALL have ports inval_req_i  input  1, and inval_idx_i  input  IDX_WIDTH: single-set invalidation request and its set index.
REQ-009 SHALL have ports wr_req_i  input  1, wr_idx_i  input  IDX_WIDTH, and wr_way_i  input  $clog2(N_WAY): refill valid-bit set request, with its set index and way.
REQ-010 SHALL have ports rd_req_i  input  1, and rd_idx_i  input  IDX_WIDTH: core lookup request and its set index.
REQ-011 SHALL have ports inval_gnt_o, wr_gnt_o, rd_gnt_o  output  1 each: combinational per-cycle grants.
REQ-012 SHALL have ports vram_en_o  output  N_WAY  per-way enable; vram_we_o  output  1  write; vram_idx_o  output  IDX_WIDTH  set address; vram_wdata_o  output  N_WAY  valid bits to write.

Function
REQ-013 SHALL implement FSM states IDLE and FLUSH, plus a flush index counter (IDX_WIDTH bits) and a flush-pending flag.
REQ-014 In IDLE with flush_req_i=1: SHALL grant nothing, and SHALL enter FLUSH next cycle with the counter at 0.
REQ-015 In IDLE with flush_req_i=0: SHALL grant exactly one requester, fixed priority inval > wr > rd; at most one gnt high per cycle.
REQ-016 An inval grant SHALL drive vram_en_o all ones, vram_we_o=1, vram_idx_o=inval_idx_i, vram_wdata_o all zeros, in the same cycle.
REQ-017 A wr grant SHALL drive vram_en_o = onehot(wr_way_i), vram_we_o=1, vram_idx_o=wr_idx_i, vram_wdata_o = onehot(wr_way_i), in the same cycle.
REQ-018 A rd grant SHALL drive vram_en_o all ones, vram_we_o=0, vram_idx_o=rd_idx_i, vram_wdata_o=0, in the same cycle.
REQ-019 With no grant and not in FLUSH, SHALL drive vram_en_o=0, vram_we_o=0, vram_idx_o=0, vram_wdata_o=0.
REQ-020 In FLUSH, every cycle SHALL drive vram_en_o all ones, vram_we_o=1, vram_idx_o=counter, vram_wdata_o=0; all gnt outputs 0; flush_busy_o=1.
REQ-021 In FLUSH, the counter SHALL increment by 1 per cycle; at counter = S-1 it SHALL wrap to 0 and the FSM SHALL return to IDLE.
REQ-022 flush_done_o SHALL be registered, high for exactly the one cycle after the counter = S-1 write.
REQ-023 A flush_req_i seen in FLUSH SHALL set flush-pending; when the walk ends with pending set, the FSM SHALL re-enter FLUSH directly (counter 0, busy stays high), clear pending, and still pulse flush_done_o for the finished walk.
REQ-024 Flush latency: req at cycle T gives writes to idx 0..S-1 at T+1..T+S and flush_done_o at T+S+1.
REQ-025 Requesters SHALL hold req and operands until granted; the block stores no request state besides flush-pending.

Reset
REQ-026 While rst_i=1 at a clock edge: SHALL set state IDLE, counter 0, pending 0, flush_done_o 0; during those cycles all gnt and vram_* outputs SHALL be 0.
REQ-027 Reset asserted mid-flush SHALL abort the walk, with no flush_done_o pulse.

Verification (IDX_WIDTH=2, N_WAY=4)
REQ-028 Priority: inval_req_i=1 idx 2, wr_req_i=1 idx 1 way 3, rd_req_i=1 idx 0 in one cycle -> only inval_gnt_o=1; en=1111, we=1, idx=2, wdata=0000.
REQ-029 Refill: wr_req_i alone, idx 3, way 2 -> wr_gnt_o=1; en=0100, we=1, wdata=0100, idx=3.
REQ-030 Flush: flush_req_i pulse at T -> writes to idx 0,1,2,3 at T+1..T+4 with en=1111, wdata=0; flush_done_o=1 at T+5 only; rd_req_i held throughout is granted first at T+5.
REQ-031 Re-flush: flush_req_i again at T+2 -> second walk writes idx 0..3 at T+5..T+8, flush_busy_o continuous T+1..T+8, flush_done_o at T+5 and T+9.
REQ-032 Reset mid-flush: rst_i=1 at T+2 -> state IDLE, flush_busy_o=0, no flush_done_o pulse; a rd_req_i after rst_i falls is granted in its first cycle.
